// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared constants for the ping-pong staging memory. It holds
//               the default address and data widths and the encoding of the
//               per-path committed-bank count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

  // Default per-bank address width (bank depth = 2**width) and word widths
  localparam int unsigned DEF_MEM_ADDR_BIT_WIDTH         = 8;
  localparam int unsigned DEF_CNNA_INPUT_DATA_BIT_WIDTH  = 128;
  localparam int unsigned DEF_CNNA_OUTPUT_DATA_BIT_WIDTH = 512;

  // Number of banks currently committed to the consumer
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

endpackage : sram_pkg

`default_nettype wire

// File: rtl/pingpong_buf.sv
// ============================================================================
// Module      : pingpong_buf
// Description : One direction of the staging memory. It holds two banks with
//               commit/release ownership handoff between a producer (write
//               port) and a consumer (registered read port).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               wr_en_i/wr_addr_i/wr_data_i - producer write into wr_bank
//               commit_i        - hand the producer bank to the consumer
//               ready_o         - a free producer bank exists (count != FULL)
//               rd_en_i/rd_addr_i - consumer read from rd_bank
//               rd_data_o/rd_valid_o - registered read result, 1-cycle latency
//               release_i       - consumer is done with rd_bank
//               avail_o         - a committed bank exists (count != EMPTY)
//               count_o         - number of committed banks (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pingpong_buf
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_MEM_ADDR_BIT_WIDTH,
  parameter int unsigned DATA_W = DEF_CNNA_INPUT_DATA_BIT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              commit_i,
  output logic              ready_o,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              release_i,
  output logic              avail_o,
  output logic [1:0]        count_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Both banks in one array, indexed by {bank, addr}
  logic [DATA_W-1:0] mem_q [2*DEPTH];

  logic [1:0]        count_q, count_d;
  logic              rd_bank_q, rd_bank_d;
  logic              wr_bank;
  logic              commit_ok, release_ok;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  assign ready_o = (count_q != FULL);
  assign avail_o = (count_q != EMPTY);
  assign count_o = count_q;

  // The producer bank sits just past the committed ones; with count in
  // 0..2 that is rd_bank toggled only when exactly one bank is committed.
  assign wr_bank = rd_bank_q ^ (count_q == ONE);

  assign commit_ok  = commit_i  && ready_o;
  assign release_ok = release_i && avail_o;
  assign wr_ok      = wr_en_i   && ready_o;
  assign rd_ok      = rd_en_i   && avail_o;

  // Gating commit by ready and release by avail resolves the simultaneous
  // cases at the count boundaries without any extra priority logic.
  always_comb begin
    count_d   = count_q;
    rd_bank_d = rd_bank_q ^ release_ok;
    unique case ({commit_ok, release_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= EMPTY;
      rd_bank_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Memory contents survive reset. Pointers are the pre-event values, so a
  // write in a commit cycle lands in the bank being committed.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[{wr_bank, wr_addr_i}] <= wr_data_i;
    end
  end

  // Read data holds whenever no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) begin
        rd_data_q <= mem_q[{rd_bank_q, rd_addr_i}];
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule : pingpong_buf

`default_nettype wire

// File: rtl/sram_pingpong.sv
// ============================================================================
// Module      : sram_pingpong
// Description : Double-buffered CNNA/UDP staging memory. It has two
//               independent ping-pong paths: the input path (UDP writes,
//               CNNA reads) and the output path (CNNA writes, UDP reads).
// Ports       : clk, rst - clock, synchronous active-high reset
//               udp_mem_* / data_from_udp_i / udp_in_commit_i  - input producer
//               cnna_mem_rd_* / data_to_cnna_* / cnna_in_release_i - input consumer
//               cnna_mem_wr_* / data_from_cnna_i / cnna_out_commit_i - output producer
//               udp_mem_rd_* / data_to_udp_* / udp_out_release_i - output consumer
//               *_ready_o, *_avail_o, in_count_o, out_count_o - ownership status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_pingpong
  import sram_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BIT_WIDTH         = DEF_MEM_ADDR_BIT_WIDTH,
  parameter int unsigned CNNA_INPUT_DATA_BIT_WIDTH  = DEF_CNNA_INPUT_DATA_BIT_WIDTH,
  parameter int unsigned CNNA_OUTPUT_DATA_BIT_WIDTH = DEF_CNNA_OUTPUT_DATA_BIT_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  // Input path producer (UDP)
  input  logic                                  udp_mem_write_en_i,
  input  logic [MEM_ADDR_BIT_WIDTH-1:0]         udp_mem_wr_address_i,
  input  logic [CNNA_INPUT_DATA_BIT_WIDTH-1:0]  data_from_udp_i,
  input  logic                                  udp_in_commit_i,
  output logic                                  udp_in_ready_o,
  // Input path consumer (CNNA)
  input  logic                                  cnna_mem_read_en_i,
  input  logic [MEM_ADDR_BIT_WIDTH-1:0]         cnna_mem_rd_address_i,
  output logic [CNNA_INPUT_DATA_BIT_WIDTH-1:0]  data_to_cnna_o,
  output logic                                  data_to_cnna_valid_o,
  input  logic                                  cnna_in_release_i,
  output logic                                  cnna_in_avail_o,
  // Output path producer (CNNA)
  input  logic                                  cnna_mem_write_en_i,
  input  logic [MEM_ADDR_BIT_WIDTH-1:0]         cnna_mem_wr_address_i,
  input  logic [CNNA_OUTPUT_DATA_BIT_WIDTH-1:0] data_from_cnna_i,
  input  logic                                  cnna_out_commit_i,
  output logic                                  cnna_out_ready_o,
  // Output path consumer (UDP)
  input  logic                                  udp_mem_read_en_i,
  input  logic [MEM_ADDR_BIT_WIDTH-1:0]         udp_mem_rd_address_i,
  output logic [CNNA_OUTPUT_DATA_BIT_WIDTH-1:0] data_to_udp_o,
  output logic                                  data_to_udp_valid_o,
  input  logic                                  udp_out_release_i,
  output logic                                  udp_out_avail_o,
  // Status
  output logic [1:0]                            in_count_o,
  output logic [1:0]                            out_count_o
);

  pingpong_buf #(
    .ADDR_W (MEM_ADDR_BIT_WIDTH),
    .DATA_W (CNNA_INPUT_DATA_BIT_WIDTH)
  ) u_in_path (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (udp_mem_write_en_i),
    .wr_addr_i  (udp_mem_wr_address_i),
    .wr_data_i  (data_from_udp_i),
    .commit_i   (udp_in_commit_i),
    .ready_o    (udp_in_ready_o),
    .rd_en_i    (cnna_mem_read_en_i),
    .rd_addr_i  (cnna_mem_rd_address_i),
    .rd_data_o  (data_to_cnna_o),
    .rd_valid_o (data_to_cnna_valid_o),
    .release_i  (cnna_in_release_i),
    .avail_o    (cnna_in_avail_o),
    .count_o    (in_count_o)
  );

  pingpong_buf #(
    .ADDR_W (MEM_ADDR_BIT_WIDTH),
    .DATA_W (CNNA_OUTPUT_DATA_BIT_WIDTH)
  ) u_out_path (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (cnna_mem_write_en_i),
    .wr_addr_i  (cnna_mem_wr_address_i),
    .wr_data_i  (data_from_cnna_i),
    .commit_i   (cnna_out_commit_i),
    .ready_o    (cnna_out_ready_o),
    .rd_en_i    (udp_mem_read_en_i),
    .rd_addr_i  (udp_mem_rd_address_i),
    .rd_data_o  (data_to_udp_o),
    .rd_valid_o (data_to_udp_valid_o),
    .release_i  (udp_out_release_i),
    .avail_o    (udp_out_avail_o),
    .count_o    (out_count_o)
  );

endmodule : sram_pingpong

`default_nettype wire

// File: doc/sram_pingpong.md
Name: sram_pingpong

Overview:
- Double-buffered successor of the CNNA/UDP staging memory. It has two independent directions:
  - Input path: UDP writes, CNNA reads.
  - Output path: CNNA writes, UDP reads.
- Each direction has two banks with explicit commit/release ownership handoff, so producer and consumer overlap without collisions.
- Depth and widths are parametrised. Reads are registered and carry a valid flag.

Parameters:
MEM_ADDR_BIT_WIDTH, 8, per-bank address width; bank depth = 2**MEM_ADDR_BIT_WIDTH
CNNA_INPUT_DATA_BIT_WIDTH, 128, word width of the input path (UDP->CNNA)
CNNA_OUTPUT_DATA_BIT_WIDTH, 512, word width of the output path (CNNA->UDP)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
udp_mem_write_en_i  input  1  write input-path producer bank
udp_mem_wr_address_i  input  MEM_ADDR_BIT_WIDTH  input-path write address
data_from_udp_i  input  CNNA_INPUT_DATA_BIT_WIDTH  input-path write data
udp_in_commit_i  input  1  pulse: producer bank filled, hand it to CNNA
udp_in_ready_o  output  1  input path has a free producer bank (count<2)
cnna_mem_read_en_i  input  1  read input-path consumer bank
cnna_mem_rd_address_i  input  MEM_ADDR_BIT_WIDTH  input-path read address
data_to_cnna_o  output  CNNA_INPUT_DATA_BIT_WIDTH  registered read data
data_to_cnna_valid_o  output  1  data_to_cnna_o updated this cycle
cnna_in_release_i  input  1  pulse: CNNA done with consumer bank
cnna_in_avail_o  output  1  input path has a committed bank (count>0)
cnna_mem_write_en_i  input  1  write output-path producer bank
cnna_mem_wr_address_i  input  MEM_ADDR_BIT_WIDTH  output-path write address
data_from_cnna_i  input  CNNA_OUTPUT_DATA_BIT_WIDTH  output-path write data
cnna_out_commit_i  input  1  pulse: output bank filled, hand to UDP
cnna_out_ready_o  output  1  output path has a free producer bank
udp_mem_read_en_i  input  1  read output-path consumer bank
udp_mem_rd_address_i  input  MEM_ADDR_BIT_WIDTH  output-path read address
data_to_udp_o  output  CNNA_OUTPUT_DATA_BIT_WIDTH  registered read data
data_to_udp_valid_o  output  1  data_to_udp_o updated this cycle
udp_out_release_i  input  1  pulse: UDP done with consumer bank
udp_out_avail_o  output  1  output path has a committed bank
in_count_o  output  2  committed banks on input path (0..2)
out_count_o  output  2  committed banks on output path (0..2)

Behaviour:
- Each path keeps the following state:
  - count, 0..2.
  - rd_bank, 1 bit.
  - wr_bank, always equal to rd_bank XOR count[0].
- Reset (rst=1 at edge), both paths:
  - count=0, rd_bank=0.
  - valid outputs=0, data outputs=0.
  - Memory contents are not reset.
  - Reset mid-transfer discards all committed banks. The first commit after reset goes to bank 0.
- ready = (count!=2); avail = (count!=0). Both are combinational from count.
- Write: accepted only when write_en and ready. It writes the word to [wr_bank][addr]. When count==2 the write is dropped and no memory changes.
- Read:
  - Accepted only when read_en and avail.
  - The next cycle, data = mem[rd_bank][addr] and valid=1. Latency is 1 cycle.
  - A read with avail=0 is ignored: valid=0 next cycle.
  - Data holds its last value whenever valid=0.
- Commit: a commit with count<2 increments count. A commit at count==2 is ignored.
- Release: a release with count>0 decrements count and toggles rd_bank. A release at count==0 is ignored.
- Simultaneous events:
  - Commit and release together with 0<count<2: count unchanged, rd_bank toggles (wr_bank toggles with it).
  - Commit and release together at count==0: commit only.
  - Commit and release together at count==2: release only.
- Write and commit in the same cycle: the write lands in the bank being committed, using the pre-commit wr_bank.
- Read and release in the same cycle: the read uses the pre-release rd_bank.
- Producer and consumer never address the same bank; the invariant follows from the ready/avail gating. Both paths operate fully concurrently, with no priority between CNNA and UDP.

Decomposition:
- Shared package sram_pkg holds:
  - Default width/depth constants.
  - Count encodings EMPTY=0, ONE=1, FULL=2.
- One sub-module, pingpong_buf, parametrised by ADDR_W and DATA_W. It contains the two-bank memory, the count/pointer control and the registered read port. It is instantiated twice: input path and output path.

Test Plan:
- Reset, UDP writes 0xA5..A5 at addr 3, commit, CNNA reads addr 3 -> in_count_o=1; next cycle data_to_cnna_o=0xA5..A5, valid=1.
- Double fill (input path):
  - UDP writes and commits bank0 (addr0=0x11) and bank1 (addr0=0x22) -> udp_in_ready_o=0.
  - A third write of 0x33 is dropped.
  - CNNA reads addr0 -> 0x11. CNNA releases, reads addr0 -> 0x22.
- Concurrent commit and release at count=1 (input path) -> count stays 1, rd_bank toggles, following read returns the newly committed bank's data.
- Read with count=0, and a release with count=0 -> valid stays 0, data_to_cnna_o holds the previous value, count stays 0.
- Output path with MEM_ADDR_BIT_WIDTH=4:
  - CNNA writes 512-bit pattern 0xDEAD..BEEF to addr 15, commits.
  - UDP reads addr 15 -> pattern returned with valid after 1 cycle.
  - Input path traffic runs concurrently with no interference.
- Reset asserted with count=2 on both paths -> counts 0, ready=1, avail=0, valids 0, next commit targets bank 0.
